// File: rtl/fsk_tx_feeder.sv
// Word source for the FSK modulator: a small FIFO behind a valid/ready port,
// emitting one word per FRAME_CYCLES-long frame and IDLE_WORD when starved.
module fsk_tx_feeder #(
  parameter int                 WIDTH        = 9,
  parameter int                 FRAME_CYCLES = 144,
  parameter int                 DEPTH        = 4,
  parameter logic [WIDTH-1:0]   IDLE_WORD    = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         dataout,
  output logic                     frame_start,
  output logic                     frame_valid,
  output logic                     underrun,
  output logic [7:0]               underrun_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CYCLES - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    frame_cnt;
  logic             armed;
  logic             boundary;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  always_comb begin
    boundary   = (frame_cnt == '0);
    fifo_empty = (level == '0);
    in_ready   = (level != LVL_FULL);
    push       = in_valid && in_ready;
    pop        = boundary && !fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt    <= CNT_LAST;
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      armed        <= 1'b0;
      dataout      <= IDLE_WORD;
      frame_valid  <= 1'b0;
      frame_start  <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      frame_cnt   <= boundary ? CNT_LAST : frame_cnt - CW'(1);
      frame_start <= boundary;
      underrun    <= boundary && fifo_empty && armed;

      if (push) begin
        wptr <= wptr + AW'(1);
      end

      if (boundary) begin
        if (pop) begin
          dataout     <= mem[rptr];
          rptr        <= rptr + AW'(1);
          frame_valid <= 1'b1;
          armed       <= 1'b1;
        end else begin
          dataout     <= IDLE_WORD;
          frame_valid <= 1'b0;
          if (armed && underrun_cnt != '1) begin
            underrun_cnt <= underrun_cnt + 8'd1;
          end
        end
      end

      // A push into an empty FIFO at the boundary is not bypassed, so the
      // only simultaneous case is non-empty push+pop, which leaves level alone.
      case ({push, pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_tx_feeder.sv
// Directed bench for fsk_tx_feeder with default parameters (9-bit, 144-cycle
// frames, 4-deep FIFO, idle word 0).
module tb_fsk_tx_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] dataout;
  logic       frame_start;
  logic       frame_valid;
  logic       underrun;
  logic [7:0] underrun_cnt;
  logic [2:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  fsk_tx_feeder #(
    .WIDTH(9),
    .FRAME_CYCLES(144),
    .DEPTH(4),
    .IDLE_WORD(9'h000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dataout(dataout),
    .frame_start(frame_start),
    .frame_valid(frame_valid),
    .underrun(underrun),
    .underrun_cnt(underrun_cnt),
    .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         e;
    logic [8:0] d;
    logic       fs;
    logic       fv;
    logic       ur;
    logic [7:0] cnt;
    logic [2:0] lvl;
    logic       rdy;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    tick();
    chk("rst_dataout", 32'(dataout), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_fs", 32'(frame_start), 32'h0);
    chk("rst_ur", 32'(underrun), 32'h0);
    chk("rst_cnt", 32'(underrun_cnt), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    reset = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int       word;
    logic [7:0] exp_cnt;
    logic     acc;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;

    tbl[0]  = '{e:1,   d:9'h000, fs:0, fv:0, ur:0, cnt:8'd0, lvl:3'd1, rdy:1};
    tbl[1]  = '{e:2,   d:9'h000, fs:0, fv:0, ur:0, cnt:8'd0, lvl:3'd2, rdy:1};
    tbl[2]  = '{e:3,   d:9'h000, fs:0, fv:0, ur:0, cnt:8'd0, lvl:3'd3, rdy:1};
    tbl[3]  = '{e:143, d:9'h000, fs:0, fv:0, ur:0, cnt:8'd0, lvl:3'd3, rdy:1};
    tbl[4]  = '{e:144, d:9'h001, fs:1, fv:1, ur:0, cnt:8'd0, lvl:3'd2, rdy:1};
    tbl[5]  = '{e:145, d:9'h001, fs:0, fv:1, ur:0, cnt:8'd0, lvl:3'd2, rdy:1};
    tbl[6]  = '{e:287, d:9'h001, fs:0, fv:1, ur:0, cnt:8'd0, lvl:3'd2, rdy:1};
    tbl[7]  = '{e:288, d:9'h002, fs:1, fv:1, ur:0, cnt:8'd0, lvl:3'd1, rdy:1};
    tbl[8]  = '{e:432, d:9'h003, fs:1, fv:1, ur:0, cnt:8'd0, lvl:3'd0, rdy:1};
    tbl[9]  = '{e:575, d:9'h003, fs:0, fv:1, ur:0, cnt:8'd0, lvl:3'd0, rdy:1};
    tbl[10] = '{e:576, d:9'h000, fs:1, fv:0, ur:1, cnt:8'd1, lvl:3'd0, rdy:1};
    tbl[11] = '{e:577, d:9'h000, fs:0, fv:0, ur:0, cnt:8'd1, lvl:3'd0, rdy:1};

    // Idle frames after reset: never an underrun because nothing armed yet.
    do_reset();
    for (int e = 1; e <= 432; e++) begin
      tick();
      chk("idle_fs", 32'(frame_start), 32'((e % 144) == 0));
      chk("idle_dataout", 32'(dataout), 32'h0);
      chk("idle_ur", 32'(underrun), 32'h0);
    end
    chk("idle_cnt", 32'(underrun_cnt), 32'h0);
    chk("idle_fv", 32'(frame_valid), 32'h0);

    // Three words back to back, then starve: table-driven checkpoints.
    do_reset();
    for (int e = 1; e <= 577; e++) begin
      in_valid = (e <= 3);
      in_data  = (e <= 3) ? 9'(e) : 9'h000;
      tick();
      for (int i = 0; i < 12; i++) begin
        if (tbl[i].e == e) begin
          chk("vec_dataout", 32'(dataout), 32'(tbl[i].d));
          chk("vec_fs", 32'(frame_start), 32'(tbl[i].fs));
          chk("vec_fv", 32'(frame_valid), 32'(tbl[i].fv));
          chk("vec_ur", 32'(underrun), 32'(tbl[i].ur));
          chk("vec_cnt", 32'(underrun_cnt), 32'(tbl[i].cnt));
          chk("vec_level", 32'(level), 32'(tbl[i].lvl));
          chk("vec_ready", 32'(in_ready), 32'(tbl[i].rdy));
        end
      end
    end
    in_valid = 1'b0;

    // Continuous producer: FIFO fills to 4, one accept per pop, ordered output.
    do_reset();
    word     = 0;
    in_valid = 1'b1;
    in_data  = 9'(word);
    for (int e = 1; e <= 5 * 144 + 2; e++) begin
      acc = in_ready;
      tick();
      if (acc) begin
        word++;
        in_data = 9'(word);
      end
      if (e == 4) begin
        chk("stream_full_level", 32'(level), 32'd4);
        chk("stream_full_ready", 32'(in_ready), 32'd0);
      end
      if (e % 144 == 0) begin
        chk("stream_dataout", 32'(dataout), 32'(e / 144 - 1));
        chk("stream_fv", 32'(frame_valid), 32'd1);
        chk("stream_pop_level", 32'(level), 32'd3);
        chk("stream_pop_ready", 32'(in_ready), 32'd1);
      end
      if (e % 144 == 1 && e > 144) begin
        chk("stream_refill_level", 32'(level), 32'd4);
        chk("stream_refill_ready", 32'(in_ready), 32'd0);
      end
    end
    in_valid = 1'b0;

    // Push into an empty FIFO exactly on the boundary edge: no bypass.
    do_reset();
    for (int e = 1; e <= 143; e++) tick();
    in_valid = 1'b1;
    in_data  = 9'h1FF;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    chk("bnd_dataout", 32'(dataout), 32'h0);
    chk("bnd_fv", 32'(frame_valid), 32'h0);
    chk("bnd_fs", 32'(frame_start), 32'h1);
    chk("bnd_ur", 32'(underrun), 32'h0);
    chk("bnd_level", 32'(level), 32'd1);
    for (int e = 1; e <= 144; e++) tick();
    chk("bnd_next_dataout", 32'(dataout), 32'h1FF);
    chk("bnd_next_fv", 32'(frame_valid), 32'h1);
    chk("bnd_next_fs", 32'(frame_start), 32'h1);
    chk("bnd_next_level", 32'(level), 32'd0);
    for (int e = 1; e <= 144; e++) tick();
    chk("bnd_starve_dataout", 32'(dataout), 32'h0);
    chk("bnd_starve_ur", 32'(underrun), 32'h1);
    chk("bnd_starve_cnt", 32'(underrun_cnt), 32'd1);

    // Keep starving the armed feeder until the counter saturates.
    exp_cnt = 8'd1;
    for (int f = 1; f <= 260; f++) begin
      for (int e = 1; e <= 144; e++) tick();
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      chk("sat_ur", 32'(underrun), 32'h1);
      chk("sat_cnt", 32'(underrun_cnt), 32'(exp_cnt));
    end
    chk("sat_final", 32'(underrun_cnt), 32'd255);

    // Mid-frame reset with three words buffered.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 9'h0A0 + 9'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("mid_pre_level", 32'(level), 32'd3);
    for (int e = 1; e <= 40; e++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_level", 32'(level), 32'd0);
    chk("mid_dataout", 32'(dataout), 32'h0);
    chk("mid_cnt", 32'(underrun_cnt), 32'd0);
    chk("mid_fs", 32'(frame_start), 32'd0);
    chk("mid_fv", 32'(frame_valid), 32'd0);
    for (int e = 1; e <= 144; e++) begin
      tick();
      chk("mid_fs_timing", 32'(frame_start), 32'(e == 144));
    end
    chk("mid_after_dataout", 32'(dataout), 32'h0);
    chk("mid_after_ur", 32'(underrun), 32'h0);
    chk("mid_after_level", 32'(level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsk_tx_feeder.md
Name: fsk_tx_feeder

Overview:
- Word source stage directly upstream of the FSK modulator; drives its 9-bit `datain`.
- Accepts words from a producer through a valid/ready handshake and buffers them in a small FIFO.
- Presents one word on `dataout` per symbol frame, held stable for exactly FRAME_CYCLES clk cycles, matching the modulator's frame timing (144 sysclk cycles per 9-bit word).
- Substitutes IDLE_WORD when starved, and flags that condition.

Parameters:
- WIDTH, 9: data word width; equals the FSK `datain` width.
- FRAME_CYCLES, 144: clk cycles each word is held on `dataout`; must be at least 2.
- DEPTH, 4: FIFO depth in words; power of two, at least 2.
- IDLE_WORD, 9'h000: value driven when no word is available.

Ports:
- clk  input  1: system clock (same clock as the FSK modulator).
- reset  input  1: synchronous, active-high reset.
- in_data  input  WIDTH: producer word.
- in_valid  input  1: in_data is valid this cycle.
- in_ready  output  1: FIFO can accept a word this cycle.
- dataout  output  WIDTH: word presented to FSK `datain`; changes only at frame boundaries.
- frame_start  output  1: one-cycle pulse in the first cycle of each frame.
- frame_valid  output  1: high while dataout holds a FIFO word; low while it holds IDLE_WORD.
- underrun  output  1: one-cycle pulse with frame_start when an armed frame had to use IDLE_WORD.
- underrun_cnt  output  8: saturating count of underrun pulses.
- level  output  clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.

Behaviour:
- All state is registered on the clk rising edge. Reset is sampled on the edge; it overrides everything else.
- Reset values:
  - dataout = IDLE_WORD; frame_valid = 0; frame_start = 0; underrun = 0; underrun_cnt = 0; level = 0.
  - FIFO pointers = 0; frame_cnt = FRAME_CYCLES-1; armed = 0; in_ready = 1.
- Frame counter:
  - frame_cnt counts FRAME_CYCLES-1 down to 0, then reloads FRAME_CYCLES-1.
  - The edge at which frame_cnt==0 is the "boundary edge". After reset, the first boundary edge is the FRAME_CYCLES-th edge with reset low.
- At the boundary edge:
  - FIFO non-empty: pop the head into dataout; frame_valid <= 1; armed <= 1.
  - FIFO empty: dataout <= IDLE_WORD; frame_valid <= 0.
  - If the FIFO is empty and armed==1: underrun <= 1 and underrun_cnt increments, saturating at 255.
  - frame_start <= 1.
- On all other edges: frame_start, underrun <= 0. dataout and frame_valid hold their values.
- Push:
  - in_ready = (level != DEPTH), driven combinationally from registered level. There is no same-cycle pass-through when full.
  - A push occurs when in_valid && in_ready.
  - Words are written at the write pointer; pointers wrap modulo DEPTH.
  - in_valid while in_ready==0 is ignored; the word is dropped and the producer must hold it.
- Simultaneous push and pop:
  - Both take effect and level is unchanged.
  - If the FIFO was empty, the pop finds it empty (IDLE_WORD, underrun if armed). The pushed word is stored for the next boundary; there is no bypass.
- level increments on push only, decrements on pop only. It never exceeds DEPTH or goes below 0.
- Latency: a word pushed into an empty FIFO appears on dataout at the next boundary edge. That is 1..FRAME_CYCLES cycles later, depending on frame phase.
- Words leave in FIFO order, and each is held exactly FRAME_CYCLES cycles.
- Reset mid-frame:
  - Discards FIFO contents and returns to the reset state.
  - The next frame starts FRAME_CYCLES edges after reset is released.
- IDLE frames before the first real word are not underruns, because armed==0.

Test Plan:
- Reset, then in_valid=0 for 3*144 cycles -> dataout=9'h000 throughout; frame_start pulses at edges 144, 288, 432; underrun never pulses; underrun_cnt=0.
- Push 9'h001,9'h002,9'h003 back-to-back right after reset -> level goes 1,2,3. dataout = 001 from edge 144, 002 from edge 288, 003 from edge 432, each stable 144 cycles with frame_valid=1. At edge 576: dataout=000, frame_valid=0, underrun=1, underrun_cnt=1.
- Hold in_valid=1 with an incrementing word from reset -> in_ready drops after 4 accepted words (level=4). It rises for one accept after each boundary pop. The output sequence 0,1,2,3,4,… has no gaps or duplicates.
- Push 9'h1FF into an empty FIFO exactly on a boundary edge -> that frame outputs IDLE_WORD. 9'h1FF appears at the following boundary; level returns to 0.
- Force more than 255 starved frames after arming -> underrun_cnt saturates at 255.
- Assert reset for 1 cycle mid-frame with level=3 -> level=0, dataout=9'h000, underrun_cnt=0. The next frame_start comes 144 edges after release.
